cdc_bus_rx: RTL and testbench
=============================

// Module: cdc_bus_rx
// PURPOSE
// - Destination (CLK-domain) end of a 4-phase REQ/ACK bus-crossing handshake.
// - A source-domain sender holds DATA_ASYNC stable, then raises REQ_ASYNC.
// - This block synchronises REQ, captures the bus and presents it as valid/ready to the local consumer.
// - It returns a level ACK for the sender to synchronise into its own domain.
// - Sits beside the reset synchroniser in every clock domain that receives configuration or data words.
// PARAMETERS
// - BUS_WIDTH   8   width of DATA_ASYNC / SYNC_DATA
// - NUM_STAGES  2   flops in the REQ synchroniser chain; legal range >= 2
// PORTS
// - CLK         in   1          destination clock
// - RST         in   1          reset, asynchronous, active-low
// - REQ_ASYNC   in   1          request level from source domain (unsynchronised)
// - DATA_ASYNC  in   BUS_WIDTH  source bus, stable while REQ_ASYNC high
// - DST_READY   in   1          local consumer can accept SYNC_DATA this cycle
// - SYNC_DATA   out  BUS_WIDTH  captured word, registered
// - DATA_VALID  out  1          SYNC_DATA holds an unaccepted word
// - ACK         out  1          acknowledge level to source domain, registered
// - PROTO_ERR   out  1          one-cycle pulse on a handshake violation
// BEHAVIOUR
// - Reset: RST is asynchronous, active-low; clock is CLK.
//   - RST low clears the sync chain, SYNC_DATA=0, DATA_VALID=0, ACK=0, PROTO_ERR=0 and state=IDLE.
// - REQ synchroniser
//   - req_sync = last stage of a NUM_STAGES shift chain, all stages reset to 0.
//   - A REQ_ASYNC rise sampled at edge 1 gives req_sync=1 after edge NUM_STAGES.
// - FSM with states IDLE, HOLD and ACK_WAIT; all outputs are registered.
//   - IDLE: on req_sync=1, load SYNC_DATA<=DATA_ASYNC, set DATA_VALID<=1, go to HOLD.
//     - DATA_VALID first high after edge NUM_STAGES+1.
//   - HOLD: DATA_VALID and SYNC_DATA are held constant.
//     - DST_READY=1 accepts the word: DATA_VALID<=0, ACK<=1, go to ACK_WAIT.
//     - req_sync=0 while DST_READY=0 is a violation: DATA_VALID<=0, PROTO_ERR<=1 for one cycle, ACK stays 0, go to IDLE.
//     - If req_sync=0 and DST_READY=1 in the same cycle, the accept wins with no error.
//   - ACK_WAIT: ACK stays high until req_sync=0; then ACK<=0 and go to IDLE.
//     - No new capture can occur before ACK has dropped, so one transfer completes per 4-phase cycle.
// - DATA_ASYNC is sampled only on the IDLE->HOLD edge.
//   - It is never passed through a synchroniser; stability comes from the protocol.
// - SYNC_DATA keeps its last value after acceptance; it is not cleared.
// - Minimum round trip per word (DST_READY tied 1): NUM_STAGES+2 cycles to ACK rise.
//   - Then NUM_STAGES+1 cycles after REQ_ASYNC falls until ACK falls.
// - Reset mid-operation: the state is discarded immediately and ACK drops asynchronously.
//   - The sender must treat an ACK fall without its REQ fall as an abort; this block takes no further action.
// - Illegal or unused state encodings recover to IDLE with outputs cleared.
// STRUCTURE
// - Shared package: state encodings (IDLE=2'b00, HOLD=2'b01, ACK_WAIT=2'b10) and a NUM_STAGES minimum-check constant.
// - Sub-module bit_sync: 1-bit, NUM_STAGES-deep, reset-to-0 synchroniser for REQ_ASYNC.
//   - bit_sync is reused by the sender for ACK.
// - Remaining logic in this file: FSM, capture register, output registers.
// - Elaboration check: NUM_STAGES < 2 is a fatal error.
// TESTING
// 1. Reset values
//    - Stimulus: RST low, random REQ_ASYNC/DATA_ASYNC.
//    - Required: SYNC_DATA=0, DATA_VALID=0, ACK=0, PROTO_ERR=0.
//    - Release RST; no activity until REQ_ASYNC rises.
// 2. Single transfer, NUM_STAGES=2, DST_READY=1
//    - Stimulus: DATA_ASYNC=8'hA5, then REQ_ASYNC rises.
//    - Required: DATA_VALID=1 with SYNC_DATA=8'hA5 after edge 3, ACK=1 after edge 4.
//    - Drop REQ_ASYNC: ACK=0 three edges later.
// 3. Back-pressure
//    - Stimulus: DST_READY=0 for 5 cycles after DATA_VALID rises, DATA_ASYNC=8'h3C.
//    - Required: DATA_VALID and SYNC_DATA=8'h3C held 5 cycles, ACK stays 0.
//    - Raise DST_READY: ACK=1 the next cycle.
// 4. Protocol error
//    - Stimulus: in HOLD with DST_READY=0, REQ_ASYNC falls.
//    - Required: DATA_VALID=0 and one-cycle PROTO_ERR=1 after req_sync falls; ACK never rises; state returns to IDLE.
// 5. Reset mid-handshake
//    - Stimulus: assert RST while in ACK_WAIT.
//    - Required: ACK=0 with no clock edge; after release, a held REQ_ASYNC=1 starts a fresh capture.
// 6. Back-to-back words, NUM_STAGES=3
//    - Stimulus: 8'h01, 8'h02, 8'h03 sent by a sender model.
//    - Required: three DATA_VALID accepts in order, no PROTO_ERR, DATA_VALID 4 edges after each REQ rise.

Source files
------------

// File: rtl/cdc_bus_rx_pkg.sv
// Shared definitions for the REQ/ACK bus-crossing receiver: FSM encodings and
// the minimum synchroniser depth.
package cdc_bus_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    HOLD     = 2'b01,
    ACK_WAIT = 2'b10
  } rx_state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_bus_rx_bit_sync.sv
// Single-bit multi-flop synchroniser, all stages reset to 0. The sender side
// reuses it to bring ACK into its own domain.
module cdc_bus_rx_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_bus_rx.sv
// Destination end of a 4-phase REQ/ACK bus crossing: synchronises REQ, captures
// the source bus once per handshake and offers it as valid/ready locally.
//
// state    | meaning
// IDLE     | waiting for synchronised REQ; ACK low
// HOLD     | word captured, DATA_VALID high until consumer accepts
// ACK_WAIT | ACK high, waiting for the sender to drop REQ
module cdc_bus_rx
  import cdc_bus_rx_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_ASYNC,
  input  logic [BUS_WIDTH-1:0] DATA_ASYNC,
  input  logic                 DST_READY,
  output logic [BUS_WIDTH-1:0] SYNC_DATA,
  output logic                 DATA_VALID,
  output logic                 ACK,
  output logic                 PROTO_ERR
);

  if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_stage_check
    $fatal(1, "cdc_bus_rx: NUM_STAGES must be at least 2");
  end

  rx_state_e            state_q, state_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 req_sync;

  cdc_bus_rx_bit_sync #(
    .STAGES (NUM_STAGES)
  ) u_req_sync (
    .CLK (CLK),
    .RST (RST),
    .d_i (REQ_ASYNC),
    .q_o (req_sync)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // DATA_ASYNC is only looked at on the IDLE->HOLD step; the protocol keeps it
  // stable there, so it never goes through a synchroniser.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_sync) begin
          data_d  = DATA_ASYNC;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (DST_READY) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK_WAIT;
        end else if (!req_sync) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ACK_WAIT: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        valid_d = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  assign SYNC_DATA  = data_q;
  assign DATA_VALID = valid_q;
  assign ACK        = ack_q;
  assign PROTO_ERR  = err_q;

endmodule

// File: tb/tb_cdc_bus_rx.sv
// Directed bench for cdc_bus_rx: one instance at NUM_STAGES=2 for the timing and
// error cases, one at NUM_STAGES=3 driven by a simple sender for back-to-back words.
module tb_cdc_bus_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;

  logic       req   = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       rdy   = 1'b0;
  logic [7:0] sd;
  logic       dv, ack, perr;

  logic       req3  = 1'b0;
  logic [7:0] data3 = 8'h00;
  logic       rdy3  = 1'b1;
  logic [7:0] sd3;
  logic       dv3, ack3, perr3;
  logic       perr3_seen = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  cdc_bus_rx #(.BUS_WIDTH(8), .NUM_STAGES(2)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_ASYNC  (req),
    .DATA_ASYNC (data),
    .DST_READY  (rdy),
    .SYNC_DATA  (sd),
    .DATA_VALID (dv),
    .ACK        (ack),
    .PROTO_ERR  (perr)
  );

  cdc_bus_rx #(.BUS_WIDTH(8), .NUM_STAGES(3)) u_dut3 (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_ASYNC  (req3),
    .DATA_ASYNC (data3),
    .DST_READY  (rdy3),
    .SYNC_DATA  (sd3),
    .DATA_VALID (dv3),
    .ACK        (ack3),
    .PROTO_ERR  (perr3)
  );

  always @(posedge CLK) begin
    #1;
    if (perr3 === 1'b1) perr3_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] words [3] = '{8'h01, 8'h02, 8'h03};

  initial begin
    // reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      req  = 1'($urandom);
      data = 8'($urandom);
      rdy  = 1'($urandom);
      tick();
    end
    check("rst sync_data", 32'(sd), 32'h00);
    check("rst valid", 32'(dv), 32'h0);
    check("rst ack", 32'(ack), 32'h0);
    check("rst proto_err", 32'(perr), 32'h0);
    req = 1'b0;
    rdy = 1'b0;
    RST = 1'b1;
    repeat (3) tick();
    check("idle valid", 32'(dv), 32'h0);
    check("idle ack", 32'(ack), 32'h0);

    // single transfer, consumer always ready
    data = 8'hA5;
    rdy  = 1'b1;
    req  = 1'b1;
    repeat (2) tick();
    check("t2 valid after edge2", 32'(dv), 32'h0);
    tick();
    check("t2 valid after edge3", 32'(dv), 32'h1);
    check("t2 sync_data", 32'(sd), 32'hA5);
    check("t2 ack after edge3", 32'(ack), 32'h0);
    tick();
    check("t2 ack after edge4", 32'(ack), 32'h1);
    check("t2 valid after accept", 32'(dv), 32'h0);
    req = 1'b0;
    repeat (2) tick();
    check("t2 ack held", 32'(ack), 32'h1);
    tick();
    check("t2 ack fall", 32'(ack), 32'h0);
    check("t2 data kept", 32'(sd), 32'hA5);

    // back-pressure: word held for five cycles while the bus changes
    rdy  = 1'b0;
    data = 8'h3C;
    req  = 1'b1;
    repeat (3) tick();
    check("t3 valid rise", 32'(dv), 32'h1);
    data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3 valid held", 32'(dv), 32'h1);
      check("t3 data held", 32'(sd), 32'h3C);
      check("t3 ack low", 32'(ack), 32'h0);
    end
    rdy = 1'b1;
    tick();
    check("t3 ack on ready", 32'(ack), 32'h1);
    check("t3 valid cleared", 32'(dv), 32'h0);
    req = 1'b0;
    repeat (3) tick();
    check("t3 ack fall", 32'(ack), 32'h0);

    // protocol error: REQ drops while word is still unaccepted
    rdy  = 1'b0;
    data = 8'h5A;
    req  = 1'b1;
    repeat (3) tick();
    check("t4 valid rise", 32'(dv), 32'h1);
    req = 1'b0;
    repeat (2) tick();
    check("t4 no early err", 32'(perr), 32'h0);
    check("t4 valid still", 32'(dv), 32'h1);
    tick();
    check("t4 proto_err", 32'(perr), 32'h1);
    check("t4 valid dropped", 32'(dv), 32'h0);
    check("t4 ack low", 32'(ack), 32'h0);
    tick();
    check("t4 err one cycle", 32'(perr), 32'h0);
    check("t4 ack still low", 32'(ack), 32'h0);

    // REQ fall and ready in the same cycle: accept wins
    data = 8'h96;
    req  = 1'b1;
    repeat (3) tick();
    check("t4b valid rise", 32'(dv), 32'h1);
    check("t4b data", 32'(sd), 32'h96);
    req = 1'b0;
    repeat (2) tick();
    rdy = 1'b1;
    tick();
    check("t4b accept ack", 32'(ack), 32'h1);
    check("t4b no err", 32'(perr), 32'h0);
    tick();
    check("t4b ack fall", 32'(ack), 32'h0);

    // reset while in ACK_WAIT
    data = 8'hC3;
    req  = 1'b1;
    repeat (4) tick();
    check("t5 ack before rst", 32'(ack), 32'h1);
    #2;
    RST = 1'b0;
    #1;
    check("t5 ack async drop", 32'(ack), 32'h0);
    check("t5 data cleared", 32'(sd), 32'h00);
    tick();
    RST = 1'b1;
    repeat (2) tick();
    check("t5 no early capture", 32'(dv), 32'h0);
    tick();
    check("t5 recapture valid", 32'(dv), 32'h1);
    check("t5 recapture data", 32'(sd), 32'hC3);
    tick();
    check("t5 recapture ack", 32'(ack), 32'h1);
    req = 1'b0;
    repeat (3) tick();
    check("t5 ack fall", 32'(ack), 32'h0);

    // back-to-back words through the 3-stage instance
    for (int w = 0; w < 3; w++) begin
      int n;
      data3 = words[w];
      req3  = 1'b1;
      repeat (3) tick();
      check("t6 valid early", 32'(dv3), 32'h0);
      tick();
      check("t6 valid at edge4", 32'(dv3), 32'h1);
      check("t6 word order", 32'(sd3), 32'(words[w]));
      n = 0;
      while (ack3 !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      check("t6 ack rise", 32'(ack3), 32'h1);
      check("t6 valid accepted", 32'(dv3), 32'h0);
      req3 = 1'b0;
      n = 0;
      while (ack3 !== 1'b0 && n < 10) begin
        tick();
        n++;
      end
      check("t6 ack fall", 32'(ack3), 32'h0);
    end
    check("t6 no proto_err", 32'(perr3_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
